// File: rtl/bcd_to_binary_if.sv
// Request/result bundle for the 3-digit BCD to binary converter.
interface bcd_to_binary_if;
    logic       start;
    logic [3:0] hundreds;
    logic [3:0] tens;
    logic [3:0] ones;
    logic       busy;
    logic       done;
    logic [9:0] binary_value;
    logic       err;

    modport master (
        output start, hundreds, tens, ones,
        input  busy, done, binary_value, err
    );

    modport slave (
        input  start, hundreds, tens, ones,
        output busy, done, binary_value, err
    );
endinterface

// File: rtl/bcd_to_binary.sv
// Sequential 3-digit BCD to 10-bit binary converter (reverse double dabble,
// one iteration per clock, ten iterations per conversion).
module bcd_to_binary (
    input  logic           clk,
    input  logic           rst_n,
    bcd_to_binary_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t      state, state_nxt;
    logic [21:0] work, work_shr, work_iter;
    logic [3:0]  cnt;
    logic        err_q;
    logic        dig_bad;
    logic        busy_q, done_q, err_o;
    logic [9:0]  bin_q;

    assign dig_bad = (bus.hundreds > 4'd9) | (bus.tens > 4'd9) | (bus.ones > 4'd9);

    // Shift right, then pull each BCD nibble that landed at >= 8 back by 3.
    always_comb begin
        work_shr  = work >> 1;
        work_iter = work_shr;
        if (work_shr[21]) work_iter[21:18] = work_shr[21:18] - 4'd3;
        if (work_shr[17]) work_iter[17:14] = work_shr[17:14] - 4'd3;
        if (work_shr[13]) work_iter[13:10] = work_shr[13:10] - 4'd3;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = dig_bad ? DONE : SHIFT;
            SHIFT:   if (cnt == 4'd9) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            work   <= '0;
            cnt    <= '0;
            err_q  <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            err_o  <= 1'b0;
            bin_q  <= '0;
        end else begin
            state  <= state_nxt;
            busy_q <= (state_nxt != IDLE);
            done_q <= 1'b0;
            case (state)
                IDLE: if (bus.start) begin
                    cnt <= '0;
                    if (dig_bad) begin
                        err_q <= 1'b1;
                        work  <= '0;
                    end else begin
                        err_q <= 1'b0;
                        work  <= {bus.hundreds, bus.tens, bus.ones, 10'b0};
                    end
                end
                SHIFT: begin
                    work <= work_iter;
                    cnt  <= cnt + 4'd1;
                end
                DONE: begin
                    // Results publish only here so they stay stable between done pulses.
                    done_q <= 1'b1;
                    err_o  <= err_q;
                    bin_q  <= err_q ? 10'd0 : work[9:0];
                    cnt    <= '0;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.err          = err_o;
    assign bus.binary_value = bin_q;
endmodule
